// File: rtl/ofm_bram_write_scheduler_if.sv
// ofm_bram_write_scheduler_if
// Bundles the PE-lane request bus and the OFM BRAM write port.
//   req_valid  : lane i offers a word
//   req_data   : lane i word at [i*DATA_W +: DATA_W]
//   req_ready  : one-hot or zero grant/accept
//   bram_we    : BRAM write enable
//   bram_addr  : BRAM word address
//   bram_wdata : BRAM write data
// master = scheduler side, slave = PE lanes + BRAM side.
interface ofm_bram_write_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 32
) ();
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      bram_we;
  logic [ADDR_W-1:0]         bram_addr;
  logic [DATA_W-1:0]         bram_wdata;

  modport master (
    input  req_valid, req_data,
    output req_ready, bram_we, bram_addr, bram_wdata
  );

  modport slave (
    output req_valid, req_data,
    input  req_ready, bram_we, bram_addr, bram_wdata
  );
endinterface

// File: rtl/ofm_bram_write_scheduler.sv
// ofm_bram_write_scheduler
// Shares the OFM BRAM write port among NUM_REQ PE output lanes. A lane owns
// the port for one pixel (wpp = OFM_C>>3 words), lanes are picked round-robin,
// and writes go to linear addresses in grant order. done pulses once the
// whole OFM_W*OFM_H map has been written.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : begin a layer (IDLE only), samples OFM_C/OFM_W/OFM_H
//   OFM_C/OFM_W/OFM_H : layer geometry
//   bus (master)      : lane request bus + BRAM write port
//   busy              : high while in RUN
//   done              : one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// RUN   | arbitrating lanes and accepting words
// FIN   | last write on the port, done pulse
module ofm_bram_write_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] OFM_C,
  input  logic [15:0] OFM_W,
  input  logic [15:0] OFM_H,
  ofm_bram_write_scheduler_if.master bus,
  output logic        busy,
  output logic        done
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDXW:0]   NUM_REQ_W = (IDXW+1)'(NUM_REQ);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t state_q, state_d;

  logic [15:0]       wpp_q;
  logic [31:0]       total_pix_q;
  logic [31:0]       pix_cnt_q;
  logic [15:0]       ch_cnt_q;
  logic [ADDR_W-1:0] word_addr_q;
  logic [IDXW-1:0]   owner_q;
  logic              own_valid_q;
  logic [IDXW-1:0]   rr_ptr_q;
  logic              bram_we_q;
  logic [ADDR_W-1:0] bram_addr_q;
  logic [DATA_W-1:0] bram_wdata_q;

  logic [15:0]       wpp_in;
  logic [31:0]       total_in;
  logic [IDXW:0]     cand;
  logic              scan_found;
  logic [IDXW-1:0]   scan_idx;
  logic [IDXW-1:0]   grant_idx;
  logic              gnt_valid;
  logic              hs;
  logic              last_word;
  logic              last_pix;

  assign wpp_in   = OFM_C >> 3;
  assign total_in = 32'(OFM_W) * 32'(OFM_H);

  // Round-robin scan starting at rr_ptr, used only when no lane owns the port.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDXW+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!scan_found && bus.req_valid[cand[IDXW-1:0]]) begin
        scan_found = 1'b1;
        scan_idx   = cand[IDXW-1:0];
      end
    end
  end

  // An owner keeps the port until its pixel is complete, even while stalled.
  assign grant_idx = own_valid_q ? owner_q : scan_idx;
  assign gnt_valid = own_valid_q | scan_found;
  assign hs        = (state_q == S_RUN) & gnt_valid & bus.req_valid[grant_idx];
  assign last_word = (ch_cnt_q == wpp_q - 16'd1);
  assign last_pix  = (pix_cnt_q == total_pix_q - 32'd1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (wpp_in == 16'd0 || total_in == 32'd0) ? S_FIN : S_RUN;
      S_RUN:  if (hs && last_word && last_pix) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.req_ready = '0;
    if (hs) bus.req_ready[grant_idx] = 1'b1;
    busy = (state_q == S_RUN);
    done = (state_q == S_FIN);
  end

  // Datapath: counters, ownership and the registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      wpp_q        <= '0;
      total_pix_q  <= '0;
      pix_cnt_q    <= '0;
      ch_cnt_q     <= '0;
      word_addr_q  <= '0;
      owner_q      <= '0;
      own_valid_q  <= 1'b0;
      rr_ptr_q     <= '0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
    end else begin
      bram_we_q <= hs;
      if (hs) begin
        bram_addr_q  <= word_addr_q;
        bram_wdata_q <= bus.req_data[grant_idx*DATA_W +: DATA_W];
        word_addr_q  <= word_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (last_word) begin
          ch_cnt_q    <= '0;
          pix_cnt_q   <= pix_cnt_q + 32'd1;
          own_valid_q <= 1'b0;
          rr_ptr_q    <= (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
        end else begin
          ch_cnt_q    <= ch_cnt_q + 16'd1;
          own_valid_q <= 1'b1;
          owner_q     <= grant_idx;
        end
      end
      if (state_q == S_IDLE && start) begin
        wpp_q       <= wpp_in;
        total_pix_q <= total_in;
        word_addr_q <= '0;
        ch_cnt_q    <= '0;
        pix_cnt_q   <= '0;
        own_valid_q <= 1'b0;
      end
    end
  end

  assign bus.bram_we    = bram_we_q;
  assign bus.bram_addr  = bram_addr_q;
  assign bus.bram_wdata = bram_wdata_q;

endmodule

// File: tb/tb_ofm_bram_write_scheduler.sv
// Testbench for ofm_bram_write_scheduler: lane driver, write scoreboard,
// directed layer scenarios.
module tb_ofm_bram_write_scheduler;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int AW = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] ofm_c = '0;
  logic [15:0] ofm_w = '0;
  logic [15:0] ofm_h = '0;
  logic        busy, done;

  ofm_bram_write_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) bus ();

  ofm_bram_write_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .OFM_C (ofm_c),
    .OFM_W (ofm_w),
    .OFM_H (ofm_h),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int busy_cnt = 0;
  int done_nw = 0;
  exp_t exp_q[$];
  logic [DW-1:0] lane_q[NR][$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int lane, input int k);
    return {8'(lane), 8'hA5, 48'(k)};
  endfunction

  task automatic expect_wr(input int addr, input logic [DW-1:0] data, input logic last);
    exp_t e;
    e.addr = AW'(addr);
    e.data = data;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Lane driver: each lane presents the head of its word queue; a word is
  // retired after the edge at which valid & ready were both high.
  initial begin
    logic [NR-1:0] hs;
    bus.req_valid = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (hs[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
        bus.req_valid[i] = (lane_q[i].size() > 0);
        bus.req_data[i*DW +: DW] = (lane_q[i].size() > 0) ? lane_q[i][0] : '0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (bus.bram_we === 1'b1) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write addr=%h data=%h", bus.bram_addr, bus.bram_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(bus.bram_addr), 64'(e.addr));
          chk("wr_data", bus.bram_wdata, e.data);
          chk("done_with_write", 64'(done), 64'(e.last));
        end
      end else if (done === 1'b1) begin
        done_nw++;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NR; i++) lane_q[i].delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 64'(bus.bram_we), 64'd0);
    chk("rst_addr", 64'(bus.bram_addr), 64'd0);
    chk("rst_wdata", bus.bram_wdata, 64'd0);
    chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit got = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1;
        break;
      end
    end
    chk(name, 64'(got), 64'd1);
    @(negedge clk);
    chk("idle_after_done", {62'd0, busy, done}, 64'd0);
    chk("exp_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic setup_four_lanes();
    ofm_c = 16'd16; ofm_w = 16'd4; ofm_h = 16'd1;
    for (int l = 0; l < NR; l++) begin
      for (int k = 0; k < 2; k++) begin
        lane_q[l].push_back(mk(l, k));
        expect_wr(l*2 + k, mk(l, k), (l == 3 && k == 1));
      end
    end
  endtask

  initial begin
    int b_busy, b_wr, b_dn;
    bit hit;

    do_reset();

    // Single lane, wpp=4, 2x2 pixels: 16 back-to-back writes
    ofm_c = 16'd32; ofm_w = 16'd2; ofm_h = 16'd2;
    for (int k = 0; k < 16; k++) begin
      lane_q[0].push_back(mk(0, k));
      expect_wr(k, mk(0, k), (k == 15));
    end
    b_busy = busy_cnt;
    pulse_start();
    wait_done("t1_done", 60);
    chk("t1_busy_cycles", 64'(busy_cnt - b_busy), 64'd16);

    // Four lanes always valid, wpp=2: grants 0,1,2,3 with no bubbles
    do_reset();
    setup_four_lanes();
    b_busy = busy_cnt;
    pulse_start();
    wait_done("t2_done", 40);
    chk("t2_busy_cycles", 64'(busy_cnt - b_busy), 64'd8);

    // Owner stalls mid-pixel: lane 3 must wait until lane 2 finishes
    do_reset();
    ofm_c = 16'd32; ofm_w = 16'd2; ofm_h = 16'd1;
    lane_q[2].push_back(mk(2, 0));
    for (int k = 0; k < 4; k++) begin
      lane_q[3].push_back(mk(3, k));
      expect_wr(k, mk(2, k), 1'b0);
    end
    for (int k = 0; k < 4; k++) expect_wr(4 + k, mk(3, k), (k == 3));
    b_wr = wr_cnt;
    pulse_start();
    repeat (8) @(negedge clk);
    chk("t3_stall_writes", 64'(wr_cnt - b_wr), 64'd1);
    chk("t3_lane3_blocked", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    for (int k = 1; k < 4; k++) lane_q[2].push_back(mk(2, k));
    wait_done("t3_done", 40);

    // Zero-size layer (wpp=0): done one cycle after start, no grants/writes
    do_reset();
    ofm_c = 16'd7; ofm_w = 16'd2; ofm_h = 16'd2;
    lane_q[0].push_back(mk(0, 99));
    b_wr = wr_cnt;
    b_dn = done_nw;
    pulse_start();
    @(negedge clk);
    chk("t4_done_next", 64'(done), 64'd1);
    chk("t4_no_ready", 64'(bus.req_ready), 64'd0);
    chk("t4_not_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("t4_done_pulse", {62'd0, busy, done}, 64'd0);
    chk("t4_no_writes", 64'(wr_cnt - b_wr), 64'd0);
    chk("t4_done_count", 64'(done_nw - b_dn), 64'd1);

    // Reset mid-layer after 5 writes, then a new layer from addr 0, rr_ptr 0
    do_reset();
    ofm_c = 16'd32; ofm_w = 16'd2; ofm_h = 16'd2;
    for (int k = 0; k < 16; k++) begin
      lane_q[0].push_back(mk(0, k));
      expect_wr(k, mk(0, k), (k == 15));
    end
    pulse_start();
    hit = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (bus.bram_we === 1'b1 && bus.bram_addr == 32'd4) begin
        hit = 1;
        break;
      end
    end
    chk("t5_reached_write5", 64'(hit), 64'd1);
    do_reset();
    ofm_c = 16'd16; ofm_w = 16'd1; ofm_h = 16'd2;
    lane_q[1].push_back(mk(1, 0)); lane_q[1].push_back(mk(1, 1));
    lane_q[0].push_back(mk(0, 0)); lane_q[0].push_back(mk(0, 1));
    expect_wr(0, mk(0, 0), 1'b0);
    expect_wr(1, mk(0, 1), 1'b0);
    expect_wr(2, mk(1, 0), 1'b0);
    expect_wr(3, mk(1, 1), 1'b1);
    pulse_start();
    wait_done("t5_done", 30);

    // start re-pulsed during RUN must be ignored
    do_reset();
    setup_four_lanes();
    b_busy = busy_cnt;
    b_dn = done_nw;
    pulse_start();
    repeat (2) @(posedge clk);
    pulse_start();
    wait_done("t6_done", 40);
    chk("t6_busy_cycles", 64'(busy_cnt - b_busy), 64'd8);
    chk("t6_no_extra_done", 64'(done_nw - b_dn), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
